// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store, fixed LATENCY, one-cycle response.
// Optional DMEM_ALIGN_CHECK_EN adds resp_err and suppresses misaligned accesses.
module dmem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic        resp_err,
`endif
  output logic        stall
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            accept, commit, bad;

  // Zeroed at time zero only; reset deliberately leaves contents alone.
  logic [31:0] mem [MEM_WORDS] = '{default: '0};

`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q, err_q;
  logic unused;
  assign unused   = ^req_addr[31:AW+2];
  assign bad      = mis_q;
  assign resp_err = (state == RESP) && err_q;
`else
  logic unused;
  assign unused = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign bad    = 1'b0;
`endif

  assign accept = (state == IDLE) && req_valid;
  // RESP always returns to IDLE, so any transition into RESP is an entry edge.
  assign commit = (state_nx == RESP);

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) state_nx = (LATENCY > 1) ? WAIT : RESP;
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == CW'(1)) state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        idx_q   <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
        cnt     <= CW'(LATENCY - 1);
`ifdef DMEM_ALIGN_CHECK_EN
        mis_q   <= |req_addr[1:0];
`endif
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
      end
      if (commit) begin
        resp_rdata <= (we_q || bad) ? 32'h0 : mem[idx_q];
`ifdef DMEM_ALIGN_CHECK_EN
        err_q      <= bad;
`endif
      end
    end
  end

  // Reset wins over the commit edge, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!reset && commit && we_q && !bad) mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic against a word-array model.
module tb_dmem_responder;
  localparam int MW  = 1024;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_we, req_ready, resp_valid, stall;
  logic [31:0] req_addr, req_wdata, resp_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        resp_err;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  dmem_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
`ifdef DMEM_ALIGN_CHECK_EN
    .resp_err(resp_err),
`endif
    .stall(stall)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Word index: byte address / 4, modulo the memory size.
  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(MW));
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0;
  endfunction

  // One access from an idle responder; reports latency (edges after acceptance), stall cycles, data.
  task automatic do_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int lat, output int stl, output logic err);
    stl = 0; lat = -1; rd = '0; err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    #1 if (stall) stl++;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int n = 1; n <= 20; n++) begin
      #1;
      if (resp_valid) begin
        lat = n; rd = resp_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
        err = resp_err;
`endif
        if (stall) stl++;
        break;
      end
      if (stall) stl++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready cyc%0d: got %b want 1", i, req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid cyc%0d: got %b want 0", i, resp_valid); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall cyc%0d: got %b want 0", i, stall); end
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata cyc%0d: got %h want 0", i, resp_rdata); end
    end
  endtask

  task automatic test_latency;
    logic [31:0] rd; int lat, stl; logic err;
    do_access(1'b1, 32'h10, 32'hDEADBEEF, rd, lat, stl, err);
    ref_mem[widx(32'h10)] = 32'hDEADBEEF;
    checks++; if (lat !== LAT) begin errors++; $display("FAIL store_latency: got %0d want %0d", lat, LAT); end
    checks++; if (stl !== LAT) begin errors++; $display("FAIL store_stall: got %0d want %0d", stl, LAT); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h want 0", rd); end
    do_access(1'b0, 32'h10, 32'h0, rd, lat, stl, err);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL load_latency: got %0d want %0d", lat, LAT); end
    checks++; if (stl !== LAT) begin errors++; $display("FAIL load_stall: got %0d want %0d", stl, LAT); end
    checks++; if (rd !== ref_read(32'h10)) begin errors++; $display("FAIL load_data: got %h want %h", rd, ref_read(32'h10)); end
    @(negedge clk); #1;
    checks++; if (resp_rdata !== ref_read(32'h10)) begin errors++; $display("FAIL rdata_hold: got %h want %h", resp_rdata, ref_read(32'h10)); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_pulse_width: got %b want 0", resp_valid); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; int lat, stl; logic err;
    do_access(1'b1, 32'h0000_1004, 32'h12345678, rd, lat, stl, err);
    ref_mem[widx(32'h0000_1004)] = 32'h12345678;
    do_access(1'b0, 32'h0000_0004, 32'h0, rd, lat, stl, err);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL wrap_load: got %h want 12345678", rd); end
    checks++; if (rd !== ref_read(32'h4)) begin errors++; $display("FAIL wrap_model: got %h want %h", rd, ref_read(32'h4)); end
  endtask

  task automatic test_back_to_back;
    int acc = 0, rsp = 0, last = -100, overlap = 0, rsp_exp = 0;
    int accs[$];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req_ready) begin
        if (acc > 0) begin
          checks++; if (i - last !== LAT + 1) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", i - last, LAT + 1); end
        end
        acc++; last = i;
      end
      if (resp_valid) begin
        rsp++;
        checks++; if (resp_rdata !== ref_read(32'h4)) begin errors++; $display("FAIL b2b_data: got %h want %h", resp_rdata, ref_read(32'h4)); end
      end
      if (req_ready && resp_valid) overlap++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int a = 0; a < 12; a += LAT + 1) begin
      accs.push_back(a);
      if (a + LAT < 12) rsp_exp++;
    end
    checks++; if (acc !== accs.size()) begin errors++; $display("FAIL b2b_accepts: got %0d want %0d", acc, accs.size()); end
    checks++; if (rsp !== rsp_exp) begin errors++; $display("FAIL b2b_responses: got %0d want %0d", rsp, rsp_exp); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_ready_in_resp: got %0d want 0", overlap); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd; int lat, stl, seen = 0; logic err;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL abort_in_wait: got stall=%b want 1", stall); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_idle_ready: got %b want 1", req_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL abort_idle_stall: got %b want 0", stall); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h want 0", resp_rdata); end
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) seen++;
      @(negedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_resp: got %0d pulses want 0", seen); end
    do_access(1'b0, 32'h20, 32'h0, rd, lat, stl, err);
    checks++; if (rd !== ref_read(32'h20)) begin errors++; $display("FAIL abort_no_write: got %h want %h", rd, ref_read(32'h20)); end
    // Reset during RESP: store already committed must survive.
    do_access(1'b1, 32'h24, 32'hC0FFEE01, rd, lat, stl, err);
    ref_mem[widx(32'h24)] = 32'hC0FFEE01;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    do_access(1'b0, 32'h24, 32'h0, rd, lat, stl, err);
    checks++; if (rd !== ref_read(32'h24)) begin errors++; $display("FAIL resp_reset_keeps_store: got %h want %h", rd, ref_read(32'h24)); end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd; int lat, stl; logic err;
`ifdef DMEM_ALIGN_CHECK_EN
    do_access(1'b1, 32'h22, 32'h5A5A1234, rd, lat, stl, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b want 1", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_rdata: got %h want 0", rd); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL mis_latency: got %0d want %0d", lat, LAT); end
    do_access(1'b0, 32'h20, 32'h0, rd, lat, stl, err);
    checks++; if (rd !== ref_read(32'h20)) begin errors++; $display("FAIL mis_unchanged: got %h want %h", rd, ref_read(32'h20)); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL aligned_err: got %b want 0", err); end
    @(negedge clk); #1;
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL err_outside_resp: got %b want 0", resp_err); end
`else
    do_access(1'b1, 32'h22, 32'h5A5A1234, rd, lat, stl, err);
    ref_mem[widx(32'h22)] = 32'h5A5A1234;
    do_access(1'b0, 32'h23, 32'h0, rd, lat, stl, err);
    checks++; if (rd !== ref_read(32'h20)) begin errors++; $display("FAIL mis_as_aligned: got %h want %h", rd, ref_read(32'h20)); end
`endif
  endtask

  task automatic test_random;
    logic [31:0] rd, a, d, exp; int lat, stl; logic err, we;
    for (int k = 0; k < 60; k++) begin
      we = 1'($urandom_range(0, 1));
      a  = ($urandom & ~32'(MW * 4 - 1)) | (32'($urandom_range(0, 31)) << 2);
`ifndef DMEM_ALIGN_CHECK_EN
      a  = a | 32'($urandom_range(0, 3));
`endif
      d  = $urandom;
      exp = we ? 32'h0 : ref_read(a);
      do_access(we, a, d, rd, lat, stl, err);
      if (we) ref_mem[widx(a)] = d;
      checks++; if (rd !== exp) begin errors++; $display("FAIL rand_data #%0d we=%b a=%h: got %h want %h", k, we, a, rd, exp); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rand_latency #%0d: got %0d want %0d", k, lat, LAT); end
      checks++; if (stl !== LAT) begin errors++; $display("FAIL rand_stall #%0d: got %0d want %0d", k, stl, LAT); end
`ifdef DMEM_ALIGN_CHECK_EN
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err #%0d: got %b want 0", k, err); end
`endif
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_wrap();
    test_back_to_back();
    test_reset_abort();
    test_misaligned();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
